// File: rtl/complex_acc.sv
// Complex frame accumulator: sums real/imag parts of FRAME_LEN accepted samples.
// One-cycle result latency; the result is held until out_ready and input stalls meanwhile.
module complex_acc #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_real,
  output logic [ACC_W-1:0] out_imag,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [ACC_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] re_ext, im_ext, re_sum, im_sum;
  logic             re_ovf, im_ovf;

  assign re_ext = {{(ACC_W-16){in_data[31]}}, in_data[31:16]};
  assign im_ext = {{(ACC_W-16){in_data[15]}}, in_data[15:0]};
  assign re_sum = acc_re_q + re_ext;
  assign im_sum = acc_im_q + im_ext;
  assign re_ovf = (acc_re_q[ACC_W-1] == re_ext[ACC_W-1]) && (re_sum[ACC_W-1] != acc_re_q[ACC_W-1]);
  assign im_ovf = (acc_im_q[ACC_W-1] == im_ext[ACC_W-1]) && (im_sum[ACC_W-1] != acc_im_q[ACC_W-1]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    ovf_d     = ovf_q;
    out_re_d  = out_re_q;
    out_im_d  = out_im_q;
    out_ovf_d = out_ovf_q;
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    if (state_q == ACCUM) begin
      // flush wins over a coincident beat, which is dropped
      if (flush) begin
        cnt_d    = '0;
        acc_re_d = '0;
        acc_im_d = '0;
        ovf_d    = 1'b0;
      end else if (in_valid) begin
        if (cnt_q == LAST) begin
          out_re_d  = re_sum;
          out_im_d  = im_sum;
          out_ovf_d = ovf_q | re_ovf | im_ovf;
          cnt_d     = '0;
          acc_re_d  = '0;
          acc_im_d  = '0;
          ovf_d     = 1'b0;
          state_d   = HOLD;
        end else begin
          acc_re_d = re_sum;
          acc_im_d = im_sum;
          ovf_d    = ovf_q | re_ovf | im_ovf;
          cnt_d    = cnt_q + 1'b1;
        end
      end
    end else if (out_ready) begin
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      ovf_q     <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      ovf_q     <= ovf_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_real = out_re_q;
  assign out_imag = out_im_q;
  assign out_ovf  = out_ovf_q;

endmodule
